// File: rtl/mux_tree_rr_arbiter_if.sv
// mux_tree_rr_arbiter_if
//   Handshake/select bundle between the requesters, the downstream sink and
//   the round-robin arbiter that steers the 2-level mux tree.
//   req[3:0]   : requests, bit0=a, bit1=b, bit2=c, bit3=d
//   ready      : downstream accepted y this cycle
//   sel1..sel3 : mux tree selects, y = sel1 ? (sel2 ? a : b) : (sel3 ? c : d)
//   gnt[3:0]   : one-hot grant, same order as req
//   gnt_valid  : a grant is active, y is valid
//   xfer       : gnt_valid & ready
//   modport master : requester/sink side (drives req, ready)
//   modport slave  : arbiter side (drives selects, grant, xfer)
interface mux_tree_rr_arbiter_if;
  logic [3:0] req;
  logic       ready;
  logic       sel1;
  logic       sel2;
  logic       sel3;
  logic [3:0] gnt;
  logic       gnt_valid;
  logic       xfer;

  modport master (
    output req, ready,
    input  sel1, sel2, sel3, gnt, gnt_valid, xfer
  );

  modport slave (
    input  req, ready,
    output sel1, sel2, sel3, gnt, gnt_valid, xfer
  );
endinterface

// File: rtl/mux_tree_rr_arbiter.sv
// mux_tree_rr_arbiter
//   Registered 4-way round-robin arbiter driving the selects of the mux tree
//   y = sel1 ? (sel2 ? a : b) : (sel3 ? c : d). One owner at a time; transfers
//   (gnt_valid & ready) are counted and, while another source requests, the
//   owner is rotated out after MAX_BURST transfers (MAX_BURST=0: unlimited).
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : mux_tree_rr_arbiter_if.slave (req, ready in; sel1/2/3, gnt,
//           gnt_valid, xfer out). Only xfer is combinational.
// Options:
//   MUX_TREE_ARB_PARK_EN : when defined, idle selects keep the last owner's
//   encoding so y keeps showing that source; otherwise idle selects are 000.
module mux_tree_rr_arbiter #(
  parameter int MAX_BURST = 4,
  parameter int CNT_W     = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mux_tree_rr_arbiter_if.slave bus
);

  typedef enum logic {IDLE, GRANT} state_e;

  localparam bit             BURST_ON = (MAX_BURST != 0);
  localparam logic [CNT_W:0] MAX_B    = (CNT_W+1)'(MAX_BURST);

  state_e           state_q, state_d;
  logic [3:0]       gnt_q, gnt_d;
  logic [2:0]       sel_q, sel_d;     // {sel1, sel2, sel3}
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       ptr_q, ptr_d;

  logic             xfer;
  logic             own_req;
  logic [3:0]       others;
  logic [CNT_W:0]   cnt_inc;
  logic             new_grant;
  logic [1:0]       new_idx;

  // First set bit of r searching start, start+1, ... with wrap.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] start);
    logic [1:0] idx;
    rr_pick = start;
    for (int i = 3; i >= 0; i--) begin
      idx = start + i[1:0];
      if (r[idx]) rr_pick = idx;
    end
  endfunction

  function automatic logic [2:0] sel_enc(input logic [1:0] idx);
    case (idx)
      2'd0:    sel_enc = 3'b110;
      2'd1:    sel_enc = 3'b100;
      2'd2:    sel_enc = 3'b001;
      default: sel_enc = 3'b000;
    endcase
  endfunction

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    sel_d     = sel_q;
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;
    new_grant = 1'b0;
    new_idx   = ptr_q;

    xfer    = (state_q == GRANT) & bus.ready;
    own_req = |(bus.req & gnt_q);
    others  = bus.req & ~gnt_q;
    cnt_inc = {1'b0, cnt_q} + 1'b1;

    case (state_q)
      IDLE: begin
        if (|bus.req) begin
          new_grant = 1'b1;
          new_idx   = rr_pick(bus.req, ptr_q);
        end
      end
      GRANT: begin
        if (!own_req) begin
          // Release; a pending request takes over with no idle bubble.
          if (|others) begin
            new_grant = 1'b1;
            new_idx   = rr_pick(others, ptr_q);
          end else begin
            state_d = IDLE;
            gnt_d   = 4'b0000;
`ifdef MUX_TREE_ARB_PARK_EN
            sel_d   = sel_q;
`else
            sel_d   = 3'b000;
`endif
          end
        end else if (BURST_ON && xfer && (cnt_inc >= MAX_B) && (|others)) begin
          // ptr_q is already owner+1, and the owner is masked out, so the
          // same source can never win a forced rotation.
          new_grant = 1'b1;
          new_idx   = rr_pick(others, ptr_q);
        end else if (BURST_ON && xfer && (cnt_inc <= MAX_B)) begin
          // Saturates at MAX_BURST when uncontended.
          cnt_d = cnt_inc[CNT_W-1:0];
        end
      end
      default: state_d = IDLE;
    endcase

    if (new_grant) begin
      state_d = GRANT;
      gnt_d   = 4'b0001 << new_idx;
      sel_d   = sel_enc(new_idx);
      cnt_d   = '0;
      ptr_d   = new_idx + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= 4'b0000;
      sel_q   <= 3'b000;
      cnt_q   <= '0;
      ptr_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_valid = (state_q == GRANT);
  assign bus.sel1      = sel_q[2];
  assign bus.sel2      = sel_q[1];
  assign bus.sel3      = sel_q[0];
  assign bus.xfer      = xfer;

endmodule

// File: tb/tb_mux_tree_rr_arbiter.sv
// tb_mux_tree_rr_arbiter
//   Directed scoreboard bench: each stimulus step pushes the outputs expected
//   during that cycle; a negedge monitor pops and compares.
module tb_mux_tree_rr_arbiter;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  typedef struct packed {
    logic [3:0] gnt;
    logic [2:0] sel;
    logic       xfer;
  } exp_t;

  exp_t exp_q[$];

`ifdef MUX_TREE_ARB_PARK_EN
  localparam logic [2:0] PARK_C = 3'b001;
`else
  localparam logic [2:0] PARK_C = 3'b000;
`endif

  localparam logic [2:0] SA = 3'b110, SB = 3'b100, SC = 3'b001, SD = 3'b000;
  localparam logic [3:0] GA = 4'b0001, GB = 4'b0010, GC = 4'b0100, GD = 4'b1000;

  mux_tree_rr_arbiter_if bus ();

  mux_tree_rr_arbiter #(.MAX_BURST(4), .CNT_W(3)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: compares whenever an expectation is queued for this cycle.
  always @(negedge clk) begin
    exp_t e;
    logic [8:0] act, req_v;
    if (exp_q.size() > 0) begin
      e     = exp_q.pop_front();
      act   = {bus.gnt, bus.gnt_valid, bus.sel1, bus.sel2, bus.sel3, bus.xfer};
      req_v = {e.gnt, |e.gnt, e.sel, e.xfer};
      tests++;
      if (act !== req_v) begin
        fails++;
        $display("FAIL cycle_chk t=%0t gnt/vld/sel/xfer got %b_%b_%b_%b want %b_%b_%b_%b",
                 $time, act[8:5], act[4], act[3:1], act[0],
                 req_v[8:5], req_v[4], req_v[3:1], req_v[0]);
      end
    end
  end

  task automatic step(input logic [3:0] r, input logic rd,
                      input logic [3:0] eg, input logic [2:0] es, input logic ex);
    exp_t e;
    bus.req   = r;
    bus.ready = rd;
    e.gnt = eg; e.sel = es; e.xfer = ex;
    exp_q.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(4'b0000, 1'b0, 4'b0000, 3'b000, 1'b0);
    step(4'b0000, 1'b0, 4'b0000, 3'b000, 1'b0);
    rst_n = 1'b1;
  endtask

  initial begin
    tests = 0; fails = 0;
    rst_n = 1'b0;
    bus.req = 4'b0000; bus.ready = 1'b0;
    @(posedge clk); #1;

    // Reset state, then idle with no requests.
    do_reset();
    for (int i = 0; i < 5; i++) step(4'b0000, 1'b1, 4'b0000, 3'b000, 1'b0);

    // Single requester c, saturating counter, release, idle park check.
    step(4'b0100, 1'b1, 4'b0000, 3'b000, 1'b0);
    for (int i = 0; i < 4; i++) step(4'b0100, 1'b1, GC, SC, 1'b1);
    step(4'b0000, 1'b1, GC, SC, 1'b1);
    step(4'b0000, 1'b1, 4'b0000, PARK_C, 1'b0);
    step(4'b0000, 1'b0, 4'b0000, PARK_C, 1'b0);

    // Full contention from pointer 0: a,b,c,d,a with 4 transfers each.
    do_reset();
    step(4'b1111, 1'b1, 4'b0000, 3'b000, 1'b0);
    for (int i = 0; i < 4; i++) step(4'b1111, 1'b1, GA, SA, 1'b1);
    for (int i = 0; i < 4; i++) step(4'b1111, 1'b1, GB, SB, 1'b1);
    for (int i = 0; i < 4; i++) step(4'b1111, 1'b1, GC, SC, 1'b1);
    for (int i = 0; i < 4; i++) step(4'b1111, 1'b1, GD, SD, 1'b1);
    step(4'b1111, 1'b1, GA, SA, 1'b1);

    // Asynchronous reset mid-grant: outputs clear before any clock edge.
    wait (exp_q.size() == 0);
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if ({bus.gnt, bus.gnt_valid, bus.sel1, bus.sel2, bus.sel3, bus.xfer} !== 9'b0) begin
      fails++;
      $display("FAIL async_reset got gnt=%b vld=%b sel=%b%b%b xfer=%b want all 0",
               bus.gnt, bus.gnt_valid, bus.sel1, bus.sel2, bus.sel3, bus.xfer);
    end
    @(posedge clk); #1;
    do_reset();

    // a owns with ready low: no transfers counted, then rotates to b.
    step(4'b0011, 1'b0, 4'b0000, 3'b000, 1'b0);
    for (int i = 0; i < 10; i++) step(4'b0011, 1'b0, GA, SA, 1'b0);
    for (int i = 0; i < 4; i++) step(4'b0011, 1'b1, GA, SA, 1'b1);
    step(4'b0011, 1'b1, GB, SB, 1'b1);
    // b drops req with xfer while d waits: zero-bubble handover to d.
    step(4'b1000, 1'b1, GB, SB, 1'b1);
    step(4'b1000, 1'b1, GD, SD, 1'b1);
    step(4'b0000, 1'b0, GD, SD, 1'b0);
    step(4'b0000, 1'b0, 4'b0000, SD, 1'b0);

    begin : drain
      int budget;
      budget = 0;
      while (exp_q.size() > 0 && budget < 100) begin
        @(posedge clk); budget++;
      end
      if (exp_q.size() > 0) begin
        tests++; fails++;
        $display("FAIL drain timeout pending=%0d want 0", exp_q.size());
      end
    end
    @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout tests=%0d", tests);
    $fatal(1, "watchdog");
  end

endmodule
